// File: rtl/adc_trig_pkg.sv
// Shared definitions for the ADC trigger controller: FSM encoding, cfg/sts field offsets,
// slope and channel constants, and the channel-select helper.
package adc_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trig_state_e;

  localparam int CFG_THR_LSB   = 0;
  localparam int CFG_THR_W     = 16;
  localparam int CFG_CHAN_BIT  = 16;
  localparam int CFG_SLOPE_BIT = 17;
  localparam int CFG_LEN_LSB   = 32;

  localparam int STS_STATE_LSB = 0;
  localparam int STS_OVF_BIT   = 2;
  localparam int STS_BUSY_BIT  = 3;
  localparam int STS_CNT_LSB   = 16;
  localparam int STS_CNT_W     = 16;

  localparam logic SLOPE_RISING  = 1'b0;
  localparam logic SLOPE_FALLING = 1'b1;
  localparam logic CHAN_A        = 1'b0;
  localparam logic CHAN_B        = 1'b1;

  // Channel A lives in the low half of the sample word, channel B in the high half.
  function automatic logic signed [15:0] sel_channel(input logic [31:0] word, input logic chan);
    return (chan == CHAN_B) ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/adc_trig_detect.sv
// Edge detector: selects the configured channel from the current and previous sample
// and reports a one-bit hit when the configured threshold crossing occurs.
module adc_trig_detect
  import adc_trig_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_prev,
  input  logic              i_valid,
  input  logic              i_prev_vld,
  input  logic [15:0]       i_threshold,
  input  logic              i_chan,
  input  logic              i_slope,
  output logic              o_hit
);

  logic signed [15:0] w_cur;
  logic signed [15:0] w_prev;
  logic signed [15:0] w_thr;
  logic               w_rise;
  logic               w_fall;

  always_comb begin
    w_cur  = sel_channel(i_sample[31:0], i_chan);
    w_prev = sel_channel(i_prev[31:0], i_chan);
    w_thr  = i_threshold;
    w_rise = (w_prev < w_thr) && (w_cur >= w_thr);
    w_fall = (w_prev > w_thr) && (w_cur <= w_thr);
    // Without a previous sample there is no edge to judge.
    o_hit  = i_valid && i_prev_vld && ((i_slope == SLOPE_FALLING) ? w_fall : w_rise);
  end

endmodule

// File: rtl/axis_adc_trig_ctrl.sv
// ADC trigger/capture controller: arms on a pulse, triggers on a threshold edge or force,
// streams N samples out on AXI-Stream. Optional trigger timestamp: ADC_TRIG_TIMESTAMP_EN.
module axis_adc_trig_ctrl
  import adc_trig_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
`ifdef ADC_TRIG_TIMESTAMP_EN
  ,parameter logic [31:0] TS_INIT = 32'd0
`endif
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [63:0]                 cfg_data,
  input  logic                        arm,
  // The force pulse: "force" itself is a reserved word in SystemVerilog.
  input  logic                        force_trig,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [31:0]                 sts_data,
  output logic [31:0]                 trig_time
);

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  trig_state_e                 r_state;
  trig_state_e                 w_next_state;
  logic [15:0]                 r_thr;
  logic                        r_chan;
  logic                        r_slope;
  logic [CNTR_WIDTH-1:0]       r_len;
  logic [CNTR_WIDTH-1:0]       r_cnt;
  logic [AXIS_TDATA_WIDTH-1:0] r_prev;
  logic                        r_prev_vld;
  logic                        r_ovf;
  logic                        r_tvalid;
  logic                        r_tlast;
  logic [AXIS_TDATA_WIDTH-1:0] r_tdata;

  logic                        w_hit;
  logic                        w_enter_arm;
  logic                        w_trig;
  logic                        w_take;
  logic                        w_last;
  logic                        w_beat_done;
  logic                        w_busy;
  logic [CNTR_WIDTH-1:0]       w_cfg_len;
  logic [CNTR_WIDTH:0]         w_cnt_nxt;
  logic [STS_CNT_W-1:0]        w_cnt_sts;

  adc_trig_detect #(
    .DATA_W (AXIS_TDATA_WIDTH)
  ) u_detect (
    .i_sample    (s_axis_tdata),
    .i_prev      (r_prev),
    .i_valid     (s_axis_tvalid),
    .i_prev_vld  (r_prev_vld),
    .i_threshold (r_thr),
    .i_chan      (r_chan),
    .i_slope     (r_slope),
    .o_hit       (w_hit)
  );

  // Output handshake: a beat transfers on any edge where m_axis_tvalid && m_axis_tready;
  // the input stream has no back-channel, so an unaccepted beat is overwritten by the next
  // captured sample and the sticky overflow flag records the loss.
  always_comb begin
    w_cfg_len   = cfg_data[CFG_LEN_LSB +: CNTR_WIDTH];
    w_enter_arm = (r_state == ST_IDLE) && arm;
    w_trig      = (r_state == ST_ARMED) && (w_hit || force_trig);
    w_take      = s_axis_tvalid && ((r_state == ST_CAPTURE) || w_trig);
    w_cnt_nxt   = {1'b0, r_cnt} + {{CNTR_WIDTH{1'b0}}, 1'b1};
    w_last      = w_take && (w_cnt_nxt == {1'b0, r_len});
    w_beat_done = r_tvalid && m_axis_tready;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (arm) w_next_state = ST_ARMED;
      ST_ARMED:   if (w_trig) w_next_state = w_last ? ST_DONE : ST_CAPTURE;
      ST_CAPTURE: if (w_last) w_next_state = ST_DONE;
      ST_DONE:    if (w_beat_done) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      ST_ARMED, ST_CAPTURE: w_busy = 1'b1;
      default:              w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_thr      <= '0;
      r_chan     <= 1'b0;
      r_slope    <= 1'b0;
      r_len      <= CNT_ONE;
      r_cnt      <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_ovf      <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tdata    <= '0;
    end else begin
      // Configuration is frozen here; later cfg_data changes only matter at the next arm.
      if (w_enter_arm) begin
        r_thr      <= cfg_data[CFG_THR_LSB +: CFG_THR_W];
        r_chan     <= cfg_data[CFG_CHAN_BIT];
        r_slope    <= cfg_data[CFG_SLOPE_BIT];
        r_len      <= (w_cfg_len == '0) ? CNT_ONE : w_cfg_len;
        r_cnt      <= '0;
        r_ovf      <= 1'b0;
        r_prev_vld <= 1'b0;
      end
      if ((r_state == ST_ARMED) && s_axis_tvalid) begin
        r_prev     <= s_axis_tdata;
        r_prev_vld <= 1'b1;
      end
      if (w_take) begin
        r_tdata  <= s_axis_tdata;
        r_tvalid <= 1'b1;
        r_tlast  <= w_last;
        r_cnt    <= r_cnt + CNT_ONE;
        if (r_tvalid && !m_axis_tready) r_ovf <= 1'b1;
      end else if (w_beat_done) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

`ifdef ADC_TRIG_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_trig_time;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ts        <= TS_INIT;
      r_trig_time <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (w_trig) r_trig_time <= r_ts;
    end
  end

  assign trig_time = r_trig_time;
`else
  assign trig_time = '0;
`endif

  assign w_cnt_sts     = STS_CNT_W'(r_cnt);
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;

  always_comb begin
    sts_data                               = '0;
    sts_data[STS_STATE_LSB +: 2]           = r_state;
    sts_data[STS_OVF_BIT]                  = r_ovf;
    sts_data[STS_BUSY_BIT]                 = w_busy;
    sts_data[STS_CNT_LSB +: STS_CNT_W]     = w_cnt_sts;
  end

endmodule

// File: doc/axis_adc_trig_ctrl.md
AXIS_ADC_TRIG_CTRL -- requirements
Module: axis_adc_trig_ctrl

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32, SHALL set the sample word width: channel A in [15:0], channel B in [31:16], both signed.
REQ-002 Parameter CNTR_WIDTH, default 16, SHALL set the record-length counter width.
REQ-003 Port aclk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port aresetn, input, 1: reset, synchronous and active-low.
REQ-005 Port cfg_data, input, 64, SHALL carry these fields:
- [15:0] threshold (signed)
- [16] channel select (0=A, 1=B)
- [17] slope (0=rising, 1=falling)
- [CNTR_WIDTH+31:32] record length N
REQ-006 Port arm, input, 1: a one-cycle pulse that arms the trigger.
REQ-007 Port force, input, 1: a one-cycle pulse that triggers immediately when armed.
REQ-008 Ports s_axis_tvalid (input, 1) and s_axis_tdata (input, AXIS_TDATA_WIDTH): the ADC sample stream; it has no tready.
REQ-009 Ports m_axis_tvalid (output, 1), m_axis_tdata (output, AXIS_TDATA_WIDTH), m_axis_tlast (output, 1) and m_axis_tready (input, 1): the captured record.
REQ-010 Port sts_data, output, 32, SHALL report:
- [1:0] state
- [2] overflow
- [3] busy
- [31:16] samples sent
REQ-011 Port trig_time, output, 32: the timestamp latched at the trigger.

Function
REQ-012 The FSM SHALL have four states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-013 In IDLE, an arm pulse SHALL move to ARMED on the next cycle and clear overflow and the sample count.
REQ-014 The trigger condition SHALL be met on a valid sample when:
- rising slope: previous selected sample < threshold and current sample >= threshold
- falling slope: previous sample > threshold and current sample <= threshold
REQ-015 In ARMED, a met trigger condition or a force pulse SHALL move to CAPTURE; the triggering sample is the first captured sample.
REQ-016 The previous-sample register SHALL update only on valid samples; the first valid sample after arming SHALL NOT trigger on the edge condition.
REQ-017 In CAPTURE, each valid input sample SHALL be presented on m_axis with a fixed latency of one register stage.
REQ-018 m_axis_tlast SHALL assert on the Nth sample, and the FSM SHALL then enter DONE.
REQ-019 If m_axis_tvalid is high and m_axis_tready is low when a new sample arrives, that sample SHALL overwrite the output register, overflow SHALL set (sticky), and the sample SHALL still count toward N.
REQ-020 N=0 SHALL be treated as N=1.
REQ-021 cfg_data SHALL be sampled on entry to ARMED, so changes made mid-capture have no effect.
REQ-022 In DONE, the FSM SHALL return to IDLE once the final beat handshakes; arm pulses received in DONE or CAPTURE SHALL be ignored.
REQ-023 A simultaneous arm and force in IDLE SHALL arm only; the force is ignored.
REQ-024 busy SHALL be high in ARMED and CAPTURE.

Reset
REQ-025 While aresetn is low at a clock edge, the block SHALL apply these values:
- state = IDLE
- m_axis_tvalid, m_axis_tlast = 0
- m_axis_tdata = 0
- overflow = 0
- counters = 0
- trig_time = 0
REQ-026 A reset applied mid-capture SHALL abort the record without asserting tlast.

Configuration
REQ-027 With ADC_TRIG_TIMESTAMP_EN defined, a 32-bit free-running counter SHALL increment every aclk, wrap modulo 2^32, and be latched into trig_time on the trigger cycle.
REQ-028 Without ADC_TRIG_TIMESTAMP_EN, the timestamp counter SHALL NOT be built and trig_time SHALL be held at 0.

Structure
REQ-029 Package adc_trig_pkg SHALL hold the state encodings, the cfg_data and sts_data field offsets, and the slope and channel constants.
REQ-030 The channel-select mux and the slope comparison SHALL be placed in sub-module adc_trig_detect, which outputs a one-bit trigger hit.

Verification
REQ-031 Rising-edge capture: threshold=100, rising slope, channel A, N=4, ramp 90,95,100,105,... with tready=1 -> 4 beats 100,105,110,115 are output, tlast on 115, and the state returns to IDLE.
REQ-032 Falling edge on channel B: threshold=-50, falling slope, channel B, samples -40,-60 -> capture starts at -60.
REQ-033 Force trigger: in ARMED with no crossing, a force pulse -> capture starts on the next valid sample, and trig_time equals the counter value on that cycle (macro on) or 0 (macro off).
REQ-034 Backpressure: N=8 with tready held low for 3 valid samples -> overflow=1 and exactly 8 samples counted, with tlast on the 8th.
REQ-035 Reset mid-capture: aresetn low after 2 beats of N=10 -> the block is in IDLE, m_axis_tvalid=0, and no tlast is produced.
REQ-036 Wrap and N=0: with the macro on, the counter is preset near 2^32-1 and crosses zero -> trig_time wraps correctly; N=0 -> a single beat is output with tlast.
